// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve slice: control-flow opcodes,
// default address width and the control-flow classification helper.
package branch_resolve_unit_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int INSN_BYTES = 4;

   // RV32 major opcodes of the control-flow instructions the predictor handles
   localparam logic [6:0] J_JAL  = 7'b1101111;
   localparam logic [6:0] B_TYPE = 7'b1100011;
   localparam logic [6:0] I_JALR = 7'b1100111;

   typedef enum logic [1:0] {
      CF_NONE   = 2'd0,
      CF_BRANCH = 2'd1,
      CF_JUMP   = 2'd2
   } cf_kind_e;

   // Any combination that includes jal/jalr (including illegal multi-hot)
   // resolves as an unconditional jump to the computed target.
   function automatic cf_kind_e cf_classify(input logic is_branch,
                                            input logic is_jal,
                                            input logic is_jalr);
      if (is_jal | is_jalr) return CF_JUMP;
      if (is_branch)        return CF_BRANCH;
      return CF_NONE;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// IF/EX side-band bus of the branch resolve unit. The master drives the
// fetched prediction and the EX outcome; the slave returns the redirect
// and performance counters.
interface branch_resolve_unit_if
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 16
);
   logic             stall;
   logic             if_valid;
   logic [XLEN-1:0]  if_pc;
   logic [XLEN-1:0]  if_pred_pc;
   logic             ex_is_branch;
   logic             ex_is_jal;
   logic             ex_is_jalr;
   logic             ex_taken;
   logic [XLEN-1:0]  ex_target;
   logic [XLEN-1:0]  ex_pc;
   logic             flush;
   logic             redirect;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispredict_cnt;

   modport master (
      output stall, if_valid, if_pc, if_pred_pc,
             ex_is_branch, ex_is_jal, ex_is_jalr, ex_taken, ex_target,
      input  ex_pc, flush, redirect, redirect_pc, branch_cnt, mispredict_cnt
   );

   modport slave (
      input  stall, if_valid, if_pc, if_pred_pc,
             ex_is_branch, ex_is_jal, ex_is_jalr, ex_taken, ex_target,
      output ex_pc, flush, redirect, redirect_pc, branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/branch_resolve_unit_pred_queue.sv
// Prediction queue: DEPTH-entry shift register of {valid, pc, pred_pc}
// from IF to EX. Holds on stall, invalidates every entry on flush.
module pred_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_pred_pc,
   output logic            head_valid,
   output logic [XLEN-1:0] head_pc,
   output logic [XLEN-1:0] head_pred_pc
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pred_pc;
   } pred_ent_t;

   logic      [DEPTH-1:0] vld_pipe;
   pred_ent_t [DEPTH-1:0] ent_q;

   // Flush wins over stall so wrong-path entries never survive a redirect;
   // only the valid bits need clearing, the payload is don't-care then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         ent_q    <= '0;
      end else if (flush) begin
         vld_pipe <= '0;
      end else if (!stall) begin
         vld_pipe[0]      <= in_valid;
         ent_q[0].pc      <= in_pc;
         ent_q[0].pred_pc <= in_pred_pc;
         for (int k = 1; k < DEPTH; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            ent_q[k]    <= ent_q[k-1];
         end
      end
   end

   assign head_valid   = vld_pipe[DEPTH-1];
   assign head_pc      = ent_q[DEPTH-1].pc;
   assign head_pred_pc = ent_q[DEPTH-1].pred_pc;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: compares the static IF prediction carried in
// pred_queue with the actual EX outcome, raises a one-cycle flush/redirect
// on mismatch, and keeps saturating resolve/mispredict counters.
// The bus interface must be instantiated with the same XLEN/CNT_W.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_resolve_unit_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             head_valid;
   logic [XLEN-1:0]  head_pc;
   logic [XLEN-1:0]  head_pred_pc;

   cf_kind_e         cf_kind;
   logic             resolve;
   logic             take_target;
   logic             mispredict;
   logic [XLEN-1:0]  seq_pc;
   logic [XLEN-1:0]  actual_pc;

   logic             flush_q;
   logic [XLEN-1:0]  redirect_pc_q;
   logic [CNT_W-1:0] branch_cnt_q;
   logic [CNT_W-1:0] mispredict_cnt_q;

   pred_queue #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_pred_queue (
      .clk          (clk),
      .rst          (rst),
      .stall        (bus.stall),
      .flush        (flush_q),
      .in_valid     (bus.if_valid),
      .in_pc        (bus.if_pc),
      .in_pred_pc   (bus.if_pred_pc),
      .head_valid   (head_valid),
      .head_pc      (head_pc),
      .head_pred_pc (head_pred_pc)
   );

   // Actual next PC of the EX instruction and its comparison with the prediction;
   // nothing resolves while stalled or while the previous redirect is in flight.
   always_comb begin
      cf_kind     = cf_classify(bus.ex_is_branch, bus.ex_is_jal, bus.ex_is_jalr);
      resolve     = head_valid & ~bus.stall & ~flush_q;
      take_target = (cf_kind == CF_JUMP) | ((cf_kind == CF_BRANCH) & bus.ex_taken);
      seq_pc      = head_pc + XLEN'(INSN_BYTES);
      actual_pc   = take_target ? bus.ex_target : seq_pc;
      mispredict  = resolve & (actual_pc != head_pred_pc);
   end

   // Registered redirect: one-cycle flush pulse, target held until the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_q       <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         flush_q <= mispredict;
         if (mispredict) redirect_pc_q <= actual_pc;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         if (resolve && (cf_kind != CF_NONE) && (branch_cnt_q != CNT_MAX))
            branch_cnt_q <= branch_cnt_q + 1'b1;
         if (mispredict && (mispredict_cnt_q != CNT_MAX))
            mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
      end
   end

   assign bus.ex_pc          = head_pc;
   assign bus.flush          = flush_q;
   assign bus.redirect       = flush_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.branch_cnt     = branch_cnt_q;
   assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. Two DUTs share the stimulus: one with
// 16-bit counters and one with 2-bit counters to exercise saturation. Expected
// redirects are queued at issue time and checked by an independent monitor.
module tb_branch_resolve_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bi ();
   branch_resolve_unit_if #(.XLEN(32), .CNT_W(2))  bs ();

   branch_resolve_unit #(.XLEN(32), .DEPTH(2), .CNT_W(16)) dut (
      .clk (clk), .rst (rst), .bus (bi)
   );
   branch_resolve_unit #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut_sat (
      .clk (clk), .rst (rst), .bus (bs)
   );

   assign bs.stall        = bi.stall;
   assign bs.if_valid     = bi.if_valid;
   assign bs.if_pc        = bi.if_pc;
   assign bs.if_pred_pc   = bi.if_pred_pc;
   assign bs.ex_is_branch = bi.ex_is_branch;
   assign bs.ex_is_jal    = bi.ex_is_jal;
   assign bs.ex_is_jalr   = bi.ex_is_jalr;
   assign bs.ex_taken     = bi.ex_taken;
   assign bs.ex_target    = bi.ex_target;

   typedef struct {
      logic [31:0] rpc;
      int          br;
      int          mp;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_br = 0;
   int   exp_mp = 0;

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] rpc);
      exp_t e;
      e.rpc = rpc;
      e.br  = exp_br;
      e.mp  = exp_mp;
      sb.push_back(e);
   endtask

   task automatic drive_ex(input logic br, input logic jal, input logic jalr,
                           input logic tk, input logic [31:0] tgt);
      bi.ex_is_branch = br;
      bi.ex_is_jal    = jal;
      bi.ex_is_jalr   = jalr;
      bi.ex_taken     = tk;
      bi.ex_target    = tgt;
   endtask

   task automatic clear_ex();
      drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_branch_cnt"},     32'(bi.branch_cnt),     32'(exp_br));
      chk({tag, "_mispredict_cnt"}, 32'(bi.mispredict_cnt), 32'(exp_mp));
      chk({tag, "_sat_branch_cnt"}, 32'(bs.branch_cnt),     32'(sat3(exp_br)));
      chk({tag, "_sat_mispred_cnt"},32'(bs.mispredict_cnt), 32'(sat3(exp_mp)));
   endtask

   // Issue one instruction alone, resolve it in EX with the given outcome, and
   // check that the pipeline is quiet again two cycles after resolution.
   task automatic run_insn(input string tag, input logic [31:0] pc, input logic [31:0] pred,
                           input logic br, input logic jal, input logic jalr, input logic tk,
                           input logic [31:0] tgt, input logic exp_fl, input logic [31:0] exp_rpc);
      bi.if_valid = 1'b1; bi.if_pc = pc; bi.if_pred_pc = pred;
      step();
      bi.if_valid = 1'b0; bi.if_pc = '0; bi.if_pred_pc = '0;
      step();
      chk({tag, "_ex_pc"}, bi.ex_pc, pc);
      drive_ex(br, jal, jalr, tk, tgt);
      if (br | jal | jalr) exp_br++;
      if (exp_fl) begin
         exp_mp++;
         push(exp_rpc);
      end
      step();
      clear_ex();
      step();
      chk({tag, "_flush_done"}, 32'(bi.flush), 32'h0);
      chk_counts(tag);
   endtask

   // With the queue empty, a mismatching EX outcome must not resolve.
   task automatic idle_probe(input string tag, input int n);
      drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'h777);
      for (int i = 0; i < n; i++) step();
      clear_ex();
      chk_counts(tag);
   endtask

   // Monitor: every flush pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && bi.flush !== 1'b0) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_flush: got flush=%b redirect_pc=0x%08h expected no flush (t=%0t)",
                     bi.flush, bi.redirect_pc, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("mon_flush",          32'(bi.flush),          32'h1);
            chk("mon_redirect",       32'(bi.redirect),       32'h1);
            chk("mon_redirect_pc",    bi.redirect_pc,         e.rpc);
            chk("mon_mispredict_cnt", 32'(bi.mispredict_cnt), 32'(e.mp));
            chk("mon_branch_cnt",     32'(bi.branch_cnt),     32'(e.br));
            chk("mon_sat_mispred",    32'(bs.mispredict_cnt), 32'(sat3(e.mp)));
            chk("mon_sat_flush",      32'(bs.flush),          32'h1);
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0)
         assert ($onehot0({bi.ex_is_branch, bi.ex_is_jal, bi.ex_is_jalr}))
         else $error("illegal stimulus: more than one control-flow kind in EX");
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      bi.stall = 1'b0; bi.if_valid = 1'b0; bi.if_pc = '0; bi.if_pred_pc = '0;
      clear_ex();

      // Reset state
      step(); step();
      chk("rst_flush",       32'(bi.flush),    32'h0);
      chk("rst_redirect",    32'(bi.redirect), 32'h0);
      chk("rst_redirect_pc", bi.redirect_pc,   32'h0);
      chk("rst_ex_pc",       bi.ex_pc,         32'h0);
      chk_counts("rst");
      rst = 1'b0;
      step();

      // 1: backward branch predicted taken, correct
      run_insn("t1", 32'h40, 32'h30, 1, 0, 0, 1, 32'h30, 0, 32'h0);
      // 2: forward branch predicted not-taken, actually taken
      run_insn("t2", 32'h40, 32'h44, 1, 0, 0, 1, 32'h80, 1, 32'h80);
      idle_probe("t2_empty", 2);
      // JAL correctly predicted; forward not-taken correct; backward wrongly taken
      run_insn("jal_ok", 32'h10, 32'h100, 0, 1, 0, 0, 32'h100, 0, 32'h0);
      run_insn("fnt_ok", 32'h50, 32'h54, 1, 0, 0, 0, 32'h90, 0, 32'h0);
      run_insn("bt_bad", 32'h60, 32'h20, 1, 0, 0, 0, 32'h20, 1, 32'h64);

      // 3: JALR mispredict, younger mispredicting entry must be squashed
      bi.if_valid = 1'b1; bi.if_pc = 32'h100; bi.if_pred_pc = 32'h104;
      step();
      bi.if_pc = 32'h104; bi.if_pred_pc = 32'h900;
      step();
      chk("t3_ex_pc_head", bi.ex_pc, 32'h100);
      drive_ex(0, 0, 1, 0, 32'h200);
      bi.if_pc = 32'h108; bi.if_pred_pc = 32'h10c;
      exp_br++; exp_mp++; push(32'h200);
      step();
      bi.if_valid = 1'b0; bi.if_pc = '0; bi.if_pred_pc = '0;
      chk("t3_ex_pc_next", bi.ex_pc, 32'h104);
      drive_ex(0, 1, 0, 0, 32'h500);
      step(); step();
      clear_ex();
      chk("t3_redirect_hold", bi.redirect_pc, 32'h200);
      chk_counts("t3");

      // 4: stall for 3 cycles with a mispredicting head
      bi.if_valid = 1'b1; bi.if_pc = 32'h200; bi.if_pred_pc = 32'h204;
      step();
      bi.if_valid = 1'b0; bi.if_pc = '0; bi.if_pred_pc = '0;
      step();
      drive_ex(1, 0, 0, 1, 32'h300);
      bi.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_stall_flush", 32'(bi.flush), 32'h0);
         chk("t4_stall_ex_pc", bi.ex_pc, 32'h200);
         chk_counts("t4_stall");
      end
      bi.stall = 1'b0;
      exp_br++; exp_mp++; push(32'h300);
      step();
      clear_ex();
      step();
      chk("t4_flush_done", 32'(bi.flush), 32'h0);
      chk_counts("t4");

      // 5: PC wrap on a non-branch, then a predictor error on a non-branch
      run_insn("t5_wrap", 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 32'hDEAD_0000, 0, 32'h0);
      run_insn("nb_bad",  32'h300, 32'h400, 0, 0, 0, 0, 32'h0, 1, 32'h304);

      // 6a: from reset, four mispredicts saturate the 2-bit counter at 3
      rst = 1'b1;
      exp_br = 0; exp_mp = 0;
      step();
      chk_counts("t6_rst");
      rst = 1'b0;
      step();
      run_insn("sat1", 32'h40, 32'h44, 1, 0, 0, 1, 32'h80, 1, 32'h80);
      run_insn("sat2", 32'h80, 32'h84, 0, 1, 0, 0, 32'hC0, 1, 32'hC0);
      run_insn("sat3", 32'hC0, 32'h10, 1, 0, 0, 0, 32'h10, 1, 32'hC4);
      run_insn("sat4", 32'hC4, 32'hC8, 0, 0, 1, 0, 32'h1000, 1, 32'h1000);

      // 6b: asynchronous reset during the flush cycle
      bi.if_valid = 1'b1; bi.if_pc = 32'h400; bi.if_pred_pc = 32'h404;
      step();
      bi.if_valid = 1'b0; bi.if_pc = '0; bi.if_pred_pc = '0;
      step();
      drive_ex(0, 1, 0, 0, 32'h800);
      step();
      clear_ex();
      chk("t6_pre_flush",       32'(bi.flush),    32'h1);
      chk("t6_pre_redirect_pc", bi.redirect_pc,   32'h800);
      #1 rst = 1'b1;
      #1;
      exp_br = 0; exp_mp = 0;
      chk("t6_async_flush",       32'(bi.flush),    32'h0);
      chk("t6_async_redirect",    32'(bi.redirect), 32'h0);
      chk("t6_async_redirect_pc", bi.redirect_pc,   32'h0);
      chk("t6_async_ex_pc",       bi.ex_pc,         32'h0);
      chk_counts("t6_async");
      step();
      rst = 1'b0;
      step();
      run_insn("t6_after", 32'h40, 32'h30, 1, 0, 0, 1, 32'h30, 0, 32'h0);

      step(); step();
      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
